gate_bist_checker: RTL and testbench

// - Synthesizable on-chip checker for the CMOS XOR/XNOR cell; the response-checking counterpart of the cell's stimulus bench.
// - Sweeps every input vector into the gate under test, waits for settling, samples xor/xnor and compares them to a golden model.
// - Reports pass/fail, error count and the first failing vector.
// - Sits beside the cmos_xor_xnor instance and is started by a single pulse from test control.

---
 rtl/gate_bist_checker_pkg.sv | 17 +
 rtl/gate_bist_golden.sv | 18 +
 rtl/gate_bist_checker.sv | 114 +++++++++++
 tb/tb_gate_bist_checker.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/gate_bist_checker_pkg.sv
// Shared definitions for the XOR/XNOR cell BIST checker.
// Holds the FSM state encodings; imported by the checker top level.
package gate_bist_checker_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DRIVE  = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  typedef enum logic [1:0] {
    StIdle   = ST_IDLE,
    StDrive  = ST_DRIVE,
    StSample = ST_SAMPLE,
    StDone   = ST_DONE
  } state_e;

endpackage

// File: rtl/gate_bist_golden.sv
// Golden model for an XOR/XNOR cell: parity and inverted parity of the input vector.
// Purely combinational so other cell checkers can reuse it.
// Ports:
//   vec       in  N_IN  vector applied to the gate under test
//   exp_xor   out 1     expected xor output (odd parity)
//   exp_xnor  out 1     expected xnor output (even parity)
module gate_bist_golden #(
  parameter int unsigned N_IN = 2
) (
  input  logic [N_IN-1:0] vec,
  output logic            exp_xor,
  output logic            exp_xnor
);

  assign exp_xor  = ^vec;
  assign exp_xnor = ~^vec;

endmodule

// File: rtl/gate_bist_checker.sv
// On-chip response checker for the CMOS XOR/XNOR cell. A start pulse sweeps every input
// vector into the gate, holds each for SETTLE cycles, samples xor/xnor and compares them
// against the golden model. Reports pass/fail, failing-vector count and first failing vector.
// Ports:
//   clk         in  1       system clock, rising edge
//   rst_n       in  1       asynchronous active-low reset
//   start_i     in  1       one-cycle pulse starting a sweep; ignored while busy
//   stim_o      out N_IN    vector driven to the gate inputs
//   xor_i       in  1       gate xor output
//   xnor_i      in  1       gate xnor output
//   busy_o      out 1       high from the cycle after an accepted start until done
//   done_o      out 1       one-cycle pulse when the sweep completes
//   pass_o      out 1       1 = no mismatches in the last sweep
//   err_cnt_o   out N_IN+1  number of failing vectors in the last sweep
//   fail_vec_o  out N_IN    first failing vector; 0 when no failures
module gate_bist_checker
  import gate_bist_checker_pkg::*;
#(
  parameter int unsigned N_IN   = 2,
  parameter int unsigned SETTLE = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  output logic [N_IN-1:0] stim_o,
  input  logic            xor_i,
  input  logic            xnor_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            pass_o,
  output logic [N_IN:0]   err_cnt_o,
  output logic [N_IN-1:0] fail_vec_o
);

  localparam int unsigned     SettleW    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SettleW-1:0] SettleInit = SettleW'(SETTLE - 1);

  state_e             state_q;
  logic [SettleW-1:0] settle_q;
  logic               exp_xor;
  logic               exp_xnor;
  logic               mismatch;

  gate_bist_golden #(
    .N_IN(N_IN)
  ) u_golden (
    .vec     (stim_o),
    .exp_xor (exp_xor),
    .exp_xnor(exp_xnor)
  );

  // Comparing both rails separately also catches xor_i == xnor_i.
  assign mismatch = (xor_i != exp_xor) || (xnor_i != exp_xnor);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      settle_q   <= '0;
      stim_o     <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      pass_o     <= 1'b0;
      err_cnt_o  <= '0;
      fail_vec_o <= '0;
    end else begin
      done_o <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start_i) begin
            state_q    <= StDrive;
            busy_o     <= 1'b1;
            stim_o     <= '0;
            settle_q   <= SettleInit;
            err_cnt_o  <= '0;
            fail_vec_o <= '0;
            pass_o     <= 1'b0;
          end
        end
        StDrive: begin
          if (settle_q == '0) begin
            state_q <= StSample;
          end else begin
            settle_q <= settle_q - SettleW'(1);
          end
        end
        StSample: begin
          if (mismatch) begin
            // Width N_IN+1 holds 2**N_IN, so this never wraps.
            err_cnt_o <= err_cnt_o + (N_IN + 1)'(1);
            if (err_cnt_o == '0) begin
              fail_vec_o <= stim_o;
            end
          end
          if (&stim_o) begin
            state_q <= StDone;
            done_o  <= 1'b1;
          end else begin
            stim_o   <= stim_o + N_IN'(1);
            settle_q <= SettleInit;
            state_q  <= StDrive;
          end
        end
        StDone: begin
          busy_o  <= 1'b0;
          pass_o  <= (err_cnt_o == '0);
          stim_o  <= '0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_bist_checker.sv
module tb_gate_bist_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start;
  logic [1:0] stim;
  logic       gx, gxn;
  logic       busy, done, pass;
  logic [2:0] err_cnt;
  logic [1:0] fail_vec;
  int         fault;  // 0 = good gate, 1 = xor stuck-at-0, 2 = xnor tied to xor

  logic       start3;
  logic [2:0] stim3;
  logic       busy3, done3, pass3;
  logic [3:0] err3;
  logic [2:0] fvec3;

  always_comb begin
    gx  = ^stim;
    gxn = ~^stim;
    if (fault == 1) gx = 1'b0;
    if (fault == 2) gxn = gx;
  end

  gate_bist_checker dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (start),
    .stim_o    (stim),
    .xor_i     (gx),
    .xnor_i    (gxn),
    .busy_o    (busy),
    .done_o    (done),
    .pass_o    (pass),
    .err_cnt_o (err_cnt),
    .fail_vec_o(fail_vec)
  );

  gate_bist_checker #(
    .N_IN  (3),
    .SETTLE(1)
  ) dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (start3),
    .stim_o    (stim3),
    .xor_i     (^stim3),
    .xnor_i    (~^stim3),
    .busy_o    (busy3),
    .done_o    (done3),
    .pass_o    (pass3),
    .err_cnt_o (err3),
    .fail_vec_o(fvec3)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int fault;
    int exp_err;
    int exp_fvec;
    int exp_pass;
    bit pulse_mid;
  } vec_t;

  vec_t tbl[5];

  // One sweep on the default instance; start accepted at edge n=1, done expected at n=13.
  task automatic do_sweep(input vec_t v);
    int  done_at = 0;
    bit  stim_ok = 1'b1;
    bit  busy_ok = 1'b1;
    fault = v.fault;
    @(negedge clk);
    start = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      start = v.pulse_mid && (n == 1 || n == 3);  // cycles in DRIVE and SAMPLE
      if (n <= 12 && stim != 2'((n - 1) / 3)) stim_ok = 1'b0;
      if (!busy) busy_ok = 1'b0;
      if (done) begin
        done_at = n;
        break;
      end
    end
    start = 1'b0;
    check("done_latency", done_at, 13);
    check("stim_sequence", int'(stim_ok), 1);
    check("busy_during_sweep", int'(busy_ok), 1);
    check("err_cnt", int'(err_cnt), v.exp_err);
    check("fail_vec", int'(fail_vec), v.exp_fvec);
    @(posedge clk);
    #1;
    check("pass", int'(pass), v.exp_pass);
    check("done_one_cycle", int'(done), 0);
    check("busy_after", int'(busy), 0);
    check("stim_after", int'(stim), 0);
    check("err_cnt_hold", int'(err_cnt), v.exp_err);
  endtask

  initial begin
    int done_cnt;
    int done_at;
    tbl[0] = '{fault: 0, exp_err: 0, exp_fvec: 0, exp_pass: 1, pulse_mid: 1'b0};
    tbl[1] = '{fault: 1, exp_err: 2, exp_fvec: 1, exp_pass: 0, pulse_mid: 1'b0};
    tbl[2] = '{fault: 2, exp_err: 4, exp_fvec: 0, exp_pass: 0, pulse_mid: 1'b0};
    tbl[3] = '{fault: 0, exp_err: 0, exp_fvec: 0, exp_pass: 1, pulse_mid: 1'b1};
    tbl[4] = '{fault: 1, exp_err: 2, exp_fvec: 1, exp_pass: 0, pulse_mid: 1'b1};

    rst_n  = 1'b0;
    start  = 1'b0;
    start3 = 1'b0;
    fault  = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_stim", int'(stim), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_pass", int'(pass), 0);
    check("rst_err_cnt", int'(err_cnt), 0);
    check("rst_fail_vec", int'(fail_vec), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 5; i++) do_sweep(tbl[i]);

    // Reset during DRIVE of vector 2 with one failure already recorded.
    fault = 1;
    @(negedge clk);
    start = 1'b1;
    for (int n = 1; n <= 7; n++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    check("pre_reset_stim", int'(stim), 2);
    check("pre_reset_err", int'(err_cnt), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_stim", int'(stim), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_err_cnt", int'(err_cnt), 0);
    check("midrst_fail_vec", int'(fail_vec), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int n = 0; n < 30; n++) begin
      @(posedge clk);
      #1;
      if (done) done_cnt++;
    end
    check("no_done_after_reset", done_cnt, 0);
    do_sweep(tbl[0]);

    // Three-input, single-cycle settle instance.
    @(negedge clk);
    start3 = 1'b1;
    done_at = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      start3 = 1'b0;
      if (done3) begin
        done_at = n;
        break;
      end
    end
    check("n3_done_latency", done_at, 17);
    @(posedge clk);
    #1;
    check("n3_pass", int'(pass3), 1);
    check("n3_err_cnt", int'(err3), 0);
    check("n3_busy", int'(busy3), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
